sap_controller_sequencer: RTL

Control unit for the SAP-1 computer. It drives a one-hot T-state ring counter and decodes the current T-state together with the instruction-register opcode into the control word. The control word sequences the program counter, MAR, RAM, instruction register, accumulator, B register, adder/subtractor and output register over the shared 8-bit W bus. It sits beside the instruction register and fans control lines out to every datapath block.

---
 rtl/sap_pkg.sv | 38 +++
 rtl/sap_ring_counter.sv | 42 ++++
 rtl/sap_controller_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-1 control constants: opcodes, one-hot T-states and control-word bit positions.
package sap_pkg;

  localparam int unsigned NUM_T_STATES = 6;
  localparam int unsigned OP_W         = 4;
  localparam int unsigned CW_W         = 12;

  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [NUM_T_STATES-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam int unsigned CW_CP = 11;
  localparam int unsigned CW_EP = 10;
  localparam int unsigned CW_LM = 9;
  localparam int unsigned CW_CE = 8;
  localparam int unsigned CW_LI = 7;
  localparam int unsigned CW_EI = 6;
  localparam int unsigned CW_LA = 5;
  localparam int unsigned CW_EA = 4;
  localparam int unsigned CW_SU = 3;
  localparam int unsigned CW_EU = 2;
  localparam int unsigned CW_LB = 1;
  localparam int unsigned CW_LO = 0;

  typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring: async clr to T1, holds when run=0 or hold=1, early wrap to T1 on wrap.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    run,
  input  logic                    hold,
  input  logic                    wrap,
  output logic [NUM_T_STATES-1:0] t_state
);

  t_state_e state_q;
  t_state_e state_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= T1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (run && !hold) begin
      if (wrap) begin
        state_d = T1;
      end else begin
        case (state_q)
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          T4:      state_d = T5;
          T5:      state_d = T6;
          T6:      state_d = T1;
          default: state_d = T1;
        endcase
      end
    end
  end

  assign t_state = state_q;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 control unit: T-state ring plus opcode decode into the control word and sticky halt.
// SAP_VARIABLE_CYCLE_EN: wrap the ring right after each opcode's last active T-state.
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned NUM_T = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [3:0]       opcode,
  output logic             cp,
  output logic             ep,
  output logic             lm,
  output logic             ce,
  output logic             li,
  output logic             ei,
  output logic             la,
  output logic             ea,
  output logic             su,
  output logic             eu,
  output logic             lb,
  output logic             lo,
  output logic             hlt,
  output logic [NUM_T-1:0] t_state
);

  logic       active_c;
  logic       hlt_set_c;
  logic       wrap_c;
  ctrl_word_t cw_c;

  sap_ring_counter u_ring (
    .clk     (clk),
    .clr     (clr),
    .run     (run),
    .hold    (hlt | hlt_set_c),
    .wrap    (wrap_c),
    .t_state (t_state)
  );

  assign active_c  = run & ~hlt & ~clr;
  assign hlt_set_c = run & ~hlt & (t_state == T4) & (opcode == OP_HLT);

`ifdef SAP_VARIABLE_CYCLE_EN
  // ADD/SUB reach T6 and wrap naturally; HLT never leaves T4.
  always_comb begin
    wrap_c = 1'b0;
    if (t_state == T4 && opcode != OP_LDA && opcode != OP_ADD &&
        opcode != OP_SUB && opcode != OP_HLT)
      wrap_c = 1'b1;
    if (t_state == T5 && opcode == OP_LDA)
      wrap_c = 1'b1;
  end
`else
  assign wrap_c = 1'b0;
`endif

  // Control-word decode; everything is squashed while idle, halted or in reset.
  always_comb begin
    cw_c = '0;
    case (t_state)
      T1: begin
        cw_c[CW_EP] = 1'b1;
        cw_c[CW_LM] = 1'b1;
      end
      T2: cw_c[CW_CP] = 1'b1;
      T3: begin
        cw_c[CW_CE] = 1'b1;
        cw_c[CW_LI] = 1'b1;
      end
      T4: begin
        if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
          cw_c[CW_EI] = 1'b1;
          cw_c[CW_LM] = 1'b1;
        end else if (opcode == OP_OUT) begin
          cw_c[CW_EA] = 1'b1;
          cw_c[CW_LO] = 1'b1;
        end
      end
      T5: begin
        if (opcode == OP_LDA) begin
          cw_c[CW_CE] = 1'b1;
          cw_c[CW_LA] = 1'b1;
        end else if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw_c[CW_CE] = 1'b1;
          cw_c[CW_LB] = 1'b1;
        end
      end
      T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw_c[CW_EU] = 1'b1;
          cw_c[CW_LA] = 1'b1;
          cw_c[CW_SU] = (opcode == OP_SUB);
        end
      end
      default: cw_c = '0;
    endcase
    if (!active_c) cw_c = '0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)            hlt <= 1'b0;
    else if (hlt_set_c) hlt <= 1'b1;
  end

  assign cp = cw_c[CW_CP];
  assign ep = cw_c[CW_EP];
  assign lm = cw_c[CW_LM];
  assign ce = cw_c[CW_CE];
  assign li = cw_c[CW_LI];
  assign ei = cw_c[CW_EI];
  assign la = cw_c[CW_LA];
  assign ea = cw_c[CW_EA];
  assign su = cw_c[CW_SU];
  assign eu = cw_c[CW_EU];
  assign lb = cw_c[CW_LB];
  assign lo = cw_c[CW_LO];

endmodule
